// File: rtl/carfield_pkg.sv
// ---------------------------------------------------------------------------
// carfield_pkg
// Shared definitions for the integer-cluster offload controller:
//   - IntClusterNumCores : default core count of the integer cluster
//   - IntClusterBootAddr : default cluster boot address (L2 port 1 base)
//   - offload_state_e    : 3-bit offload sequencer state, IDLE..DONE; the
//                          encoding is visible to the host via status_o
// ---------------------------------------------------------------------------
package carfield_pkg;

  localparam int unsigned IntClusterNumCores = 8;
  localparam logic [31:0] IntClusterBootAddr = 32'h7800_0000;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSettle  = 3'd1,
    StRstHold = 3'd2,
    StDeiso   = 3'd3,
    StRun     = 3'd4,
    StDrain   = 3'd5,
    StDone    = 3'd6
  } offload_state_e;

endpackage

// File: rtl/carfield_intcluster_offload_ctrl.sv
// ---------------------------------------------------------------------------
// carfield_intcluster_offload_ctrl
// Sequences one offload on the integer cluster: ungate clock, let it settle,
// hold then release cluster reset, drop isolation, boot the selected cores,
// wait for end of computation, re-isolate, re-gate and raise a sticky IRQ.
//
// Optional feature macro: CARFIELD_INTCLUSTER_WDT_EN
//   When defined, a TimeoutWidth-bit watchdog runs in DEISO/RUN/DRAIN. At
//   all-ones it acts as an abort (DEISO/RUN) or forces DONE (DRAIN).
//   When undefined, those states wait indefinitely.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   launch_valid_i/ready_o  launch handshake (ready only in IDLE)
//   launch_boot_addr_i      entry point latched on launch
//   launch_core_mask_i      cores to enable (zero mask skips RUN)
//   abort_i                 host abort pulse
//   irq_clear_i             clears done_irq_o (loses against a DONE set)
//   cl_clk_en_o, cl_rst_no  cluster clock gate enable / reset
//   cl_isolate_o            AXI isolation request; cl_isolated_i its ack
//   cl_fetch_en_o           per-core fetch enable
//   cl_boot_addr_o          boot address to the cluster
//   cl_busy_i, cl_eoc_i     cluster busy / end of computation
//   done_irq_o              sticky completion interrupt
//   status_o                current state encoding
//   error_o                 sticky: abort or timeout in the last run
// ---------------------------------------------------------------------------
module carfield_intcluster_offload_ctrl
  import carfield_pkg::*;
#(
  parameter int unsigned          NumCores     = IntClusterNumCores,
  parameter int unsigned          AddrWidth    = 32,
  parameter logic [AddrWidth-1:0] BootAddrRst  = AddrWidth'(IntClusterBootAddr),
  parameter int unsigned          ClkSettleCyc = 4,
  parameter int unsigned          RstHoldCyc   = 8
`ifdef CARFIELD_INTCLUSTER_WDT_EN
  ,
  parameter int unsigned          TimeoutWidth = 24
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 launch_valid_i,
  output logic                 launch_ready_o,
  input  logic [AddrWidth-1:0] launch_boot_addr_i,
  input  logic [NumCores-1:0]  launch_core_mask_i,
  input  logic                 abort_i,
  input  logic                 irq_clear_i,
  output logic                 cl_clk_en_o,
  output logic                 cl_rst_no,
  output logic                 cl_isolate_o,
  input  logic                 cl_isolated_i,
  output logic [NumCores-1:0]  cl_fetch_en_o,
  output logic [AddrWidth-1:0] cl_boot_addr_o,
  input  logic                 cl_busy_i,
  input  logic                 cl_eoc_i,
  output logic                 done_irq_o,
  output logic [2:0]           status_o,
  output logic                 error_o
);

  // Counters are loaded with N-1 so that a phase of N cycles ends when the
  // counter reads zero; width covers the larger of the two phases.
  localparam int unsigned CntMax   = (ClkSettleCyc > RstHoldCyc) ? ClkSettleCyc : RstHoldCyc;
  localparam int unsigned CntWidth = (CntMax > 1) ? $clog2(CntMax) : 1;

  offload_state_e       stateReg, stateNext;
  logic [CntWidth-1:0]  cntReg, cntNext;
  logic [AddrWidth-1:0] bootAddrReg, bootAddrNext;
  logic [NumCores-1:0]  maskReg, maskNext;
  logic [NumCores-1:0]  fetchEnReg, fetchEnNext;
  logic                 clkEnReg, clkEnNext;
  logic                 rstNReg, rstNNext;
  logic                 isolateReg, isolateNext;
  logic                 doneIrqReg, doneIrqNext;
  logic                 errorReg, errorNext;
  logic                 fire, abortHit, timeout;

  assign fire = launch_valid_i && (stateReg == StIdle);

`ifdef CARFIELD_INTCLUSTER_WDT_EN
  logic [TimeoutWidth-1:0] wdtReg, wdtNext;

  assign timeout = &wdtReg;

  // Cleared at launch and again when RUN is entered; saturates at all-ones
  // so a timeout seen in RUN still forces DONE once DRAIN is reached.
  always_comb begin
    wdtNext = wdtReg;
    if (fire || (stateReg == StDeiso && stateNext == StRun)) begin
      wdtNext = '0;
    end else if ((stateReg inside {StDeiso, StRun, StDrain}) && !timeout) begin
      wdtNext = wdtReg + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wdtReg <= '0;
    else         wdtReg <= wdtNext;
  end
`else
  assign timeout = 1'b0;
`endif

  // Abort (or watchdog expiry) only matters before DRAIN; DRAIN/DONE ignore it.
  assign abortHit = (abort_i && (stateReg inside {StSettle, StRstHold, StDeiso, StRun})) ||
                    (timeout && (stateReg inside {StDeiso, StRun}));

  always_comb begin
    stateNext    = stateReg;
    cntNext      = cntReg;
    bootAddrNext = bootAddrReg;
    maskNext     = maskReg;
    fetchEnNext  = fetchEnReg;
    clkEnNext    = clkEnReg;
    rstNNext     = rstNReg;
    isolateNext  = isolateReg;
    errorNext    = errorReg;

    unique case (stateReg)
      StIdle: begin
        if (fire) begin
          bootAddrNext = launch_boot_addr_i;
          maskNext     = launch_core_mask_i;
          errorNext    = 1'b0;
          clkEnNext    = 1'b1;
          cntNext      = CntWidth'(ClkSettleCyc - 1);
          stateNext    = StSettle;
        end
      end
      StSettle: begin
        if (cntReg == '0) begin
          cntNext   = CntWidth'(RstHoldCyc - 1);
          stateNext = StRstHold;
        end else begin
          cntNext = cntReg - 1'b1;
        end
      end
      StRstHold: begin
        if (cntReg == '0) begin
          rstNNext    = 1'b1;
          isolateNext = 1'b0;
          stateNext   = StDeiso;
        end else begin
          cntNext = cntReg - 1'b1;
        end
      end
      StDeiso: begin
        if (!cl_isolated_i) begin
          if (maskReg != '0) begin
            fetchEnNext = maskReg;
            stateNext   = StRun;
          end else begin
            // Nothing to boot: go straight to re-isolation.
            isolateNext = 1'b1;
            stateNext   = StDrain;
          end
        end
      end
      StRun: begin
        if (cl_eoc_i) begin
          fetchEnNext = '0;
          isolateNext = 1'b1;
          stateNext   = StDrain;
        end
      end
      StDrain: begin
        if ((cl_isolated_i && !cl_busy_i) || timeout) begin
          rstNNext  = 1'b0;
          clkEnNext = 1'b0;
          stateNext = StDone;
        end
      end
      StDone: begin
        stateNext = StIdle;
      end
      default: begin
        stateNext = StIdle;
      end
    endcase

    if (abortHit) begin
      fetchEnNext = '0;
      isolateNext = 1'b1;
      errorNext   = 1'b1;
      stateNext   = StDrain;
    end
  end

  // Set is held for both the entry edge and the DONE cycle itself so that a
  // clear landing on either loses against the completion.
  always_comb begin
    doneIrqNext = doneIrqReg;
    if (stateNext == StDone || stateReg == StDone) begin
      doneIrqNext = 1'b1;
    end else if (irq_clear_i) begin
      doneIrqNext = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stateReg    <= StIdle;
      cntReg      <= '0;
      bootAddrReg <= BootAddrRst;
      maskReg     <= '0;
      fetchEnReg  <= '0;
      clkEnReg    <= 1'b0;
      rstNReg     <= 1'b0;
      isolateReg  <= 1'b1;
      doneIrqReg  <= 1'b0;
      errorReg    <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      cntReg      <= cntNext;
      bootAddrReg <= bootAddrNext;
      maskReg     <= maskNext;
      fetchEnReg  <= fetchEnNext;
      clkEnReg    <= clkEnNext;
      rstNReg     <= rstNNext;
      isolateReg  <= isolateNext;
      doneIrqReg  <= doneIrqNext;
      errorReg    <= errorNext;
    end
  end

  assign launch_ready_o = (stateReg == StIdle);
  assign cl_clk_en_o    = clkEnReg;
  assign cl_rst_no      = rstNReg;
  assign cl_isolate_o   = isolateReg;
  assign cl_fetch_en_o  = fetchEnReg;
  assign cl_boot_addr_o = bootAddrReg;
  assign done_irq_o     = doneIrqReg;
  assign error_o        = errorReg;
  assign status_o       = stateReg;

endmodule

// File: tb/tb_carfield_intcluster_offload_ctrl.sv
// ---------------------------------------------------------------------------
// tb_carfield_intcluster_offload_ctrl
// Drives offload launches against the controller while playing the cluster
// (isolation ack, busy, eoc). Expected timing and values come from the
// launch rules: clock +1, reset release +1+settle+hold, fetch enable after
// isolation drop, sticky IRQ/error tracked in a small model.
// Build with CARFIELD_INTCLUSTER_WDT_EN to add the watchdog scenario.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_carfield_intcluster_offload_ctrl;

  localparam int NC = 8;
  localparam int AW = 32;
  localparam int SETTLE_CYC = 4;
  localparam int HOLD_CYC = 8;
  localparam logic [AW-1:0] BOOT_RST = 32'h7800_0000;

  // Status encoding, in state order IDLE..DONE.
  localparam logic [2:0] S_IDLE = 3'd0, S_SETTLE = 3'd1, S_RSTHOLD = 3'd2, S_DEISO = 3'd3,
                         S_RUN = 3'd4, S_DRAIN = 3'd5, S_DONE = 3'd6;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          launchValid = 1'b0;
  logic          ready;
  logic [AW-1:0] launchAddr = '0;
  logic [NC-1:0] launchMask = '0;
  logic          abortIn = 1'b0;
  logic          irqClear = 1'b0;
  logic          clkEn, clRstN, iso;
  logic          clIsolated = 1'b1;
  logic [NC-1:0] fetchEn;
  logic [AW-1:0] bootAddr;
  logic          clBusy = 1'b0;
  logic          clEoc = 1'b0;
  logic          doneIrq;
  logic [2:0]    status;
  logic          error;

  int compared = 0;
  int mismatched = 0;
  logic modelIrq = 1'b0;

  always #5 clk = ~clk;

  carfield_intcluster_offload_ctrl #(
    .NumCores(NC), .AddrWidth(AW), .BootAddrRst(BOOT_RST),
    .ClkSettleCyc(SETTLE_CYC), .RstHoldCyc(HOLD_CYC)
`ifdef CARFIELD_INTCLUSTER_WDT_EN
    , .TimeoutWidth(8)
`endif
  ) dut (
    .clk_i(clk), .rst_ni(rstN),
    .launch_valid_i(launchValid), .launch_ready_o(ready),
    .launch_boot_addr_i(launchAddr), .launch_core_mask_i(launchMask),
    .abort_i(abortIn), .irq_clear_i(irqClear),
    .cl_clk_en_o(clkEn), .cl_rst_no(clRstN), .cl_isolate_o(iso),
    .cl_isolated_i(clIsolated), .cl_fetch_en_o(fetchEn), .cl_boot_addr_o(bootAddr),
    .cl_busy_i(clBusy), .cl_eoc_i(clEoc),
    .done_irq_o(doneIrq), .status_o(status), .error_o(error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full offload starting from IDLE. abortAt < 0 means no abort.
  task automatic run_offload(input logic [AW-1:0] addr, input logic [NC-1:0] mask,
                             input int isoDly, input int eocDly, input int abortAt,
                             input int busyDly, input bit holdValid, input bit clearAtDone,
                             input logic [AW-1:0] heldAddr);
    bit aborted;
    logic [2:0] expSt;
    aborted = 1'b0;
    launchValid = 1'b1; launchAddr = addr; launchMask = mask;
    compared++;
    if (ready !== 1'b1 || status !== S_IDLE) begin
      mismatched++;
      $display("FAIL ready_idle: got ready=%b status=%0d want ready=1 status=%0d", ready, status, S_IDLE);
    end
    tick();
    if (holdValid) begin launchAddr = heldAddr; launchMask = ~mask; end
    else launchValid = 1'b0;
    compared++;
    if ({clkEn, clRstN, error, ready, status} !== {1'b1, 1'b0, 1'b0, 1'b0, S_SETTLE} ||
        bootAddr !== addr || doneIrq !== modelIrq) begin
      mismatched++;
      $display("FAIL launch_accept: got clk_en=%b rst_n=%b err=%b rdy=%b st=%0d addr=%h irq=%b want 1 0 0 0 %0d %h %b",
               clkEn, clRstN, error, ready, status, bootAddr, doneIrq, S_SETTLE, addr, modelIrq);
    end
    for (int i = 0; i < SETTLE_CYC + HOLD_CYC - 1; i++) begin
      tick();
      expSt = (i + 1 < SETTLE_CYC) ? S_SETTLE : S_RSTHOLD;
      compared++;
      if ({clRstN, clkEn, iso, status} !== {1'b0, 1'b1, 1'b1, expSt} || fetchEn !== '0) begin
        mismatched++;
        $display("FAIL rst_hold[%0d]: got rst_n=%b clk_en=%b iso=%b st=%0d fetch=%h want 0 1 1 %0d 00",
                 i, clRstN, clkEn, iso, status, fetchEn, expSt);
      end
    end
    tick();
    compared++;
    if ({clRstN, iso, status} !== {1'b1, 1'b0, S_DEISO}) begin
      mismatched++;
      $display("FAIL rst_release: got rst_n=%b iso=%b st=%0d want 1 0 %0d", clRstN, iso, status, S_DEISO);
    end
    for (int i = 0; i < isoDly; i++) begin
      tick();
      compared++;
      if (status !== S_DEISO || fetchEn !== '0) begin
        mismatched++;
        $display("FAIL deiso_wait: got st=%0d fetch=%h want %0d 00", status, fetchEn, S_DEISO);
      end
    end
    clIsolated = 1'b0;
    tick();
    if (mask == '0) begin
      compared++;
      if ({status, iso} !== {S_DRAIN, 1'b1} || fetchEn !== '0) begin
        mismatched++;
        $display("FAIL zero_mask_skip: got st=%0d iso=%b fetch=%h want %0d 1 00", status, iso, fetchEn, S_DRAIN);
      end
    end else begin
      compared++;
      if (status !== S_RUN || fetchEn !== mask) begin
        mismatched++;
        $display("FAIL run_entry: got st=%0d fetch=%h want %0d %h", status, fetchEn, S_RUN, mask);
      end
      for (int i = 0; i < eocDly && !aborted; i++) begin
        if (i == abortAt) begin
          abortIn = 1'b1; tick(); abortIn = 1'b0; aborted = 1'b1;
        end else begin
          tick();
          compared++;
          if (status !== S_RUN || fetchEn !== mask || ready !== 1'b0 || bootAddr !== addr || doneIrq !== modelIrq) begin
            mismatched++;
            $display("FAIL run_hold: got st=%0d fetch=%h rdy=%b addr=%h irq=%b want %0d %h 0 %h %b",
                     status, fetchEn, ready, bootAddr, doneIrq, S_RUN, mask, addr, modelIrq);
          end
        end
      end
      if (!aborted) begin clEoc = 1'b1; tick(); clEoc = 1'b0; end
      compared++;
      if ({status, iso, error} !== {S_DRAIN, 1'b1, aborted} || fetchEn !== '0) begin
        mismatched++;
        $display("FAIL drain_entry: got st=%0d iso=%b err=%b fetch=%h want %0d 1 %b 00",
                 status, iso, error, fetchEn, S_DRAIN, aborted);
      end
    end
    clIsolated = 1'b1; clBusy = 1'b1;
    for (int i = 0; i < busyDly; i++) begin
      tick();
      compared++;
      if (status !== S_DRAIN || doneIrq !== modelIrq || iso !== 1'b1) begin
        mismatched++;
        $display("FAIL drain_wait: got st=%0d irq=%b iso=%b want %0d %b 1", status, doneIrq, iso, S_DRAIN, modelIrq);
      end
    end
    clBusy = 1'b0;
    tick();
    modelIrq = 1'b1;
    compared++;
    if ({status, doneIrq, clkEn, clRstN, iso, error} !== {S_DONE, 1'b1, 1'b0, 1'b0, 1'b1, aborted}) begin
      mismatched++;
      $display("FAIL done_state: got st=%0d irq=%b clk_en=%b rst_n=%b iso=%b err=%b want %0d 1 0 0 1 %b",
               status, doneIrq, clkEn, clRstN, iso, error, S_DONE, aborted);
    end
    if (clearAtDone) irqClear = 1'b1;
    tick();
    compared++;
    if ({status, ready, doneIrq} !== {S_IDLE, 1'b1, 1'b1}) begin
      mismatched++;
      $display("FAIL back_idle: got st=%0d rdy=%b irq=%b want %0d 1 1", status, ready, doneIrq, S_IDLE);
    end
    if (clearAtDone) begin
      tick();
      irqClear = 1'b0;
      modelIrq = 1'b0;
      compared++;
      if (doneIrq !== 1'b0) begin
        mismatched++;
        $display("FAIL irq_clear_after_done: got irq=%b want 0", doneIrq);
      end
    end
    $display("launch addr=%h mask=%h iso=%0d eoc=%0d abort=%0d busy=%0d done", addr, mask, isoDly, eocDly, aborted, busyDly);
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (3) tick();
    compared++;
    if ({ready, clkEn, clRstN, iso, doneIrq, error, status} !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_IDLE} ||
        fetchEn !== '0 || bootAddr !== BOOT_RST) begin
      mismatched++;
      $display("FAIL reset_values: got rdy=%b clk_en=%b rst_n=%b iso=%b irq=%b err=%b st=%0d fetch=%h addr=%h",
               ready, clkEn, clRstN, iso, doneIrq, error, status, fetchEn, bootAddr);
    end
    rstN = 1'b1;
    tick();
    compared++;
    if (status !== S_IDLE || clkEn !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release: got st=%0d clk_en=%b want %0d 0", status, clkEn, S_IDLE);
    end
  endtask

  task automatic test_spec_launch();
    run_offload(32'h7800_0100, 8'hFF, 0, 50, -1, 2, 1'b0, 1'b0, '0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 5; n++) begin
      run_offload($urandom, NC'($urandom_range(255, 1)), $urandom_range(3, 0), $urandom_range(20, 0),
                  -1, $urandom_range(3, 0), 1'b0, 1'b0, '0);
    end
  endtask

  task automatic test_zero_mask();
    run_offload(32'h7800_0200, 8'h00, 1, 0, -1, 1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_abort();
    run_offload(32'h7800_0300, 8'h5A, 0, 10, 3, 2, 1'b0, 1'b0, '0);
    // Abort while the clock is still settling: straight to DRAIN.
    launchValid = 1'b1; launchAddr = 32'h7800_0400; launchMask = 8'h01;
    tick();
    launchValid = 1'b0;
    abortIn = 1'b1;
    tick();
    abortIn = 1'b0;
    compared++;
    if ({status, error, iso} !== {S_DRAIN, 1'b1, 1'b1} || fetchEn !== '0) begin
      mismatched++;
      $display("FAIL abort_settle: got st=%0d err=%b iso=%b fetch=%h want %0d 1 1 00", status, error, iso, fetchEn, S_DRAIN);
    end
    tick();
    tick();
    compared++;
    if ({status, doneIrq, error} !== {S_IDLE, 1'b1, 1'b1}) begin
      mismatched++;
      $display("FAIL abort_settle_done: got st=%0d irq=%b err=%b want %0d 1 1", status, doneIrq, error, S_IDLE);
    end
    modelIrq = 1'b1;
    $display("launch addr=78000400 mask=01 abort in settle done");
  endtask

  task automatic test_back_to_back();
    run_offload(32'h7800_0500, 8'h3C, 1, 5, -1, 1, 1'b1, 1'b0, 32'h7800_0600);
    run_offload(32'h7800_0600, 8'hC3, 0, 2, -1, 0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_irq_clear();
    run_offload(32'h7800_0700, 8'h81, 0, 3, -1, 1, 1'b0, 1'b1, '0);
    run_offload(32'h7800_0800, 8'h18, 0, 3, -1, 0, 1'b0, 1'b0, '0);
    irqClear = 1'b1;
    tick();
    irqClear = 1'b0;
    modelIrq = 1'b0;
    compared++;
    if (doneIrq !== 1'b0) begin
      mismatched++;
      $display("FAIL irq_clear_idle: got irq=%b want 0", doneIrq);
    end
    run_offload(32'h7800_0900, 8'h42, 0, 1, -1, 0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_async_reset();
    launchValid = 1'b1; launchAddr = 32'h7800_0A00; launchMask = 8'h0F;
    tick();
    launchValid = 1'b0;
    repeat (SETTLE_CYC + HOLD_CYC) tick();
    clIsolated = 1'b0;
    tick();
    compared++;
    if (status !== S_RUN || fetchEn !== 8'h0F) begin
      mismatched++;
      $display("FAIL async_pre_run: got st=%0d fetch=%h want %0d 0f", status, fetchEn, S_RUN);
    end
    #3 rstN = 1'b0;
    #1;
    compared++;
    if ({ready, clkEn, clRstN, iso, doneIrq, error, status} !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_IDLE} ||
        fetchEn !== '0 || bootAddr !== BOOT_RST) begin
      mismatched++;
      $display("FAIL async_reset: got rdy=%b clk_en=%b rst_n=%b iso=%b irq=%b err=%b st=%0d fetch=%h addr=%h",
               ready, clkEn, clRstN, iso, doneIrq, error, status, fetchEn, bootAddr);
    end
    modelIrq = 1'b0;
    clIsolated = 1'b1;
    #2 rstN = 1'b1;
    tick();
    $display("launch addr=78000a00 mask=0f async reset in run");
  endtask

`ifdef CARFIELD_INTCLUSTER_WDT_EN
  task automatic test_wdt();
    launchValid = 1'b1; launchAddr = 32'h7800_0B00; launchMask = 8'hFF;
    tick();
    launchValid = 1'b0;
    repeat (SETTLE_CYC + HOLD_CYC) tick();
    clIsolated = 1'b0;
    tick();
    repeat (255) tick();
    compared++;
    if (error !== 1'b0 || status !== S_RUN) begin
      mismatched++;
      $display("FAIL wdt_early: got err=%b st=%0d want 0 %0d", error, status, S_RUN);
    end
    tick();
    compared++;
    if ({error, status} !== {1'b1, S_DRAIN} || fetchEn !== '0) begin
      mismatched++;
      $display("FAIL wdt_timeout: got err=%b st=%0d fetch=%h want 1 %0d 00", error, status, fetchEn, S_DRAIN);
    end
    tick();
    compared++;
    if (status !== S_DONE) begin
      mismatched++;
      $display("FAIL wdt_drain_force: got st=%0d want %0d", status, S_DONE);
    end
    modelIrq = 1'b1;
    clIsolated = 1'b1;
    tick();
    $display("launch addr=78000b00 mask=ff watchdog timeout");
  endtask
`endif

  initial begin
    test_reset();
    test_spec_launch();
    test_random();
    test_zero_mask();
    test_abort();
    test_back_to_back();
    test_irq_clear();
`ifdef CARFIELD_INTCLUSTER_WDT_EN
    test_wdt();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
